// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 receiver types, constants and parity helper
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PS2_EXT_CODE   = 8'hE0;
    localparam logic [7:0] PS2_BRK_CODE   = 8'hF0;
    localparam int         PS2_FRAME_BITS = 11;
    localparam int         PS2_DATA_BITS  = 8;

    // PS/2 uses odd parity: data bits plus parity bit must hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// rtl/ps2_sync_filter.sv - 2-FF sync of PS/2 pins, clock deglitch filter and falling-edge strobe
module ps2_sync_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_ps2_clk,
    input  logic i_ps2_data,
    output logic o_fe,
    output logic o_data
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic          r_clk_s1;
    logic          r_clk_s2;
    logic          r_dat_s1;
    logic          r_dat_s2;
    logic          r_filt;
    logic          r_filt_prev;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_s1    <= 1'b1;
            r_clk_s2    <= 1'b1;
            r_dat_s1    <= 1'b1;
            r_dat_s2    <= 1'b1;
            r_filt      <= 1'b1;
            r_filt_prev <= 1'b1;
            r_cnt       <= '0;
        end else begin
            r_clk_s1    <= i_ps2_clk;
            r_clk_s2    <= r_clk_s1;
            r_dat_s1    <= i_ps2_data;
            r_dat_s2    <= r_dat_s1;
            r_filt_prev <= r_filt;
            // The filtered clock only follows after FILTER_LEN consecutive differing samples.
            if (r_clk_s2 == r_filt) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
                r_filt <= r_clk_s2;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_fe   = r_filt_prev & ~r_filt;
    assign o_data = r_dat_s2;

endmodule

// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 keyboard receiver emitting make/break key events with E0/F0 prefixes stripped
// Optional parity enforcement: define PS2_PARITY_CHECK_EN.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] code_o,
    output logic       code_valid_o,
    output logic       ext_o,
    output logic       brk_o,
    output logic       frame_err_o,
    output logic       busy_o
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic        w_fe;
    logic        w_data;
    logic        w_par_ok;
    logic        w_shift_en;
    logic        w_stop_fe;
    logic        w_timeout_hit;

    ps2_state_t  r_state;
    ps2_state_t  w_state_next;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic [TW-1:0] r_to_cnt;
    logic        r_ext;
    logic        r_brk;
    logic [7:0]  r_code;
    logic        r_code_valid;
    logic        r_ext_o;
    logic        r_brk_o;
    logic        r_frame_err;

    ps2_sync_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_sync_filter (
        .clk        (clk),
        .rst        (rst),
        .i_ps2_clk  (ps2_clk),
        .i_ps2_data (ps2_data),
        .o_fe       (w_fe),
        .o_data     (w_data)
    );

`ifdef PS2_PARITY_CHECK_EN
    logic r_parity;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_parity <= 1'b0;
        end else if (r_state == ST_PARITY && w_fe) begin
            r_parity <= w_data;
        end
    end

    assign w_par_ok = odd_parity_ok(r_shift, r_parity);
`else
    assign w_par_ok = 1'b1;
`endif

    // A falling edge in the same cycle as expiry keeps the frame alive.
    assign w_timeout_hit = (r_state != ST_IDLE) && !w_fe
                           && (r_to_cnt == TW'(TIMEOUT_CYC - 1));

    always_comb begin
        w_state_next = r_state;
        w_shift_en   = 1'b0;
        w_stop_fe    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_fe && !w_data) begin
                    w_state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_fe) begin
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == 3'(PS2_DATA_BITS - 1)) begin
                        w_state_next = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (w_fe) begin
                    w_state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_fe) begin
                    w_stop_fe    = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
        if (w_timeout_hit) begin
            w_state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_to_cnt     <= '0;
            r_ext        <= 1'b0;
            r_brk        <= 1'b0;
            r_code       <= '0;
            r_code_valid <= 1'b0;
            r_ext_o      <= 1'b0;
            r_brk_o      <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_code_valid <= 1'b0;
            r_frame_err  <= 1'b0;

            if (r_state == ST_IDLE) begin
                r_bit_cnt <= '0;
            end else if (w_shift_en) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end

            if (w_shift_en) begin
                r_shift[r_bit_cnt] <= w_data;
            end

            if (r_state == ST_IDLE || w_fe) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end

            if (w_stop_fe) begin
                if (w_data && w_par_ok) begin
                    if (r_shift == PS2_EXT_CODE) begin
                        r_ext <= 1'b1;
                    end else if (r_shift == PS2_BRK_CODE) begin
                        r_brk <= 1'b1;
                    end else begin
                        r_code       <= r_shift;
                        r_ext_o      <= r_ext;
                        r_brk_o      <= r_brk;
                        r_code_valid <= 1'b1;
                        r_ext        <= 1'b0;
                        r_brk        <= 1'b0;
                    end
                end else begin
                    r_frame_err <= 1'b1;
                    r_ext       <= 1'b0;
                    r_brk       <= 1'b0;
                end
            end

            if (w_timeout_hit) begin
                r_frame_err <= 1'b1;
                r_ext       <= 1'b0;
                r_brk       <= 1'b0;
            end
        end
    end

    assign code_o       = r_code;
    assign code_valid_o = r_code_valid;
    assign ext_o        = r_ext_o;
    assign brk_o        = r_brk_o;
    assign frame_err_o  = r_frame_err;
    assign busy_o       = (r_state != ST_IDLE);

endmodule
